// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared state/opcode-class types and nibble width for the nibble sequencer
package alu_seq_pkg;
  localparam int NW = 4;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
  typedef enum logic [1:0] {CLS_ARITH, CLS_LOGIC, CLS_REJECT} op_class_e;
  function automatic op_class_e op_class(input logic [3:0] op);
    return op[3] ? CLS_REJECT : op[2] ? CLS_LOGIC : CLS_ARITH;
  endfunction
endpackage

// File: rtl/alu_seq_nibble_mux.sv
// alu_seq_nibble_mux: picks nibble idx_i out of the latched operands
module alu_seq_nibble_mux
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int IW = 2
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [IW-1:0]    idx_i,
  output logic [NW-1:0]    a_nib_o,
  output logic [NW-1:0]    b_nib_o
);
  assign a_nib_o = a_i[NW*idx_i +: NW];
  assign b_nib_o = b_i[NW*idx_i +: NW];
endmodule

// File: rtl/alu_nibble_sequencer.sv
// alu_nibble_sequencer: runs WIDTH-bit ops one nibble per cycle on a shared 4-bit ALU, LSB first.
// Define SEQ_FLAGS_EN to add the rsp_zero flag output.
module alu_nibble_sequencer
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  input  logic             cmd_cin,
  input  logic             cmd_abort,
  output logic [3:0]       alu_op,
  output logic [3:0]       alu_a,
  output logic [3:0]       alu_b,
  output logic             alu_cin,
  input  logic [3:0]       alu_result,
  input  logic             alu_cout,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_cout,
  output logic             rsp_err,
  output logic             busy
`ifdef SEQ_FLAGS_EN
  ,
  output logic             rsp_zero
`endif
);
  localparam int NIBBLES = WIDTH / NW;
  localparam int IW = NIBBLES > 1 ? $clog2(NIBBLES) : 1;
  state_e           state_q;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] rsp_result_q;
  logic [IW-1:0]    idx_q;
  logic             carry_q;
  logic             rsp_cout_q;
  logic             rsp_err_q;
  logic             run;
  logic             arith;
  logic             last;
  op_class_e        cmd_cls;
  logic [NW-1:0]    a_nib;
  logic [NW-1:0]    b_nib;

  alu_seq_nibble_mux #(.WIDTH(WIDTH), .IW(IW)) u_mux (
    .a_i     (a_q),
    .b_i     (b_q),
    .idx_i   (idx_q),
    .a_nib_o (a_nib),
    .b_nib_o (b_nib)
  );

  assign cmd_cls = op_class(cmd_op);
  assign arith   = op_class(op_q) == CLS_ARITH;
  assign last    = idx_q == IW'(NIBBLES - 1);
  assign run     = state_q == RUN;

  // ALU-facing signals are held at zero outside RUN so the display shows nothing stale
  assign alu_op     = run ? op_q : '0;
  assign alu_a      = run ? a_nib : '0;
  assign alu_b      = run ? b_nib : '0;
  assign alu_cin    = run && carry_q;
  assign cmd_ready  = state_q == IDLE;
  assign rsp_valid  = state_q == DONE;
  assign busy       = state_q != IDLE;
  assign rsp_result = rsp_result_q;
  assign rsp_cout   = rsp_cout_q;
  assign rsp_err    = rsp_err_q;
`ifdef SEQ_FLAGS_EN
  assign rsp_zero   = rsp_valid && rsp_result_q == '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      op_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      idx_q        <= '0;
      carry_q      <= 1'b0;
      rsp_result_q <= '0;
      rsp_cout_q   <= 1'b0;
      rsp_err_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (cmd_valid) begin
          op_q         <= cmd_op;
          a_q          <= cmd_a;
          b_q          <= cmd_b;
          idx_q        <= '0;
          carry_q      <= cmd_cls == CLS_ARITH && cmd_cin;
          rsp_result_q <= '0;
          rsp_cout_q   <= 1'b0;
          rsp_err_q    <= cmd_cls == CLS_REJECT;
          state_q      <= cmd_cls == CLS_REJECT ? DONE : RUN;
        end
        RUN: if (cmd_abort) begin
          rsp_result_q <= '0;
          state_q      <= IDLE;
        end else begin
          rsp_result_q[NW*idx_q +: NW] <= alu_result;
          carry_q <= arith && alu_cout;
          idx_q   <= idx_q + IW'(1);
          if (last) begin
            rsp_cout_q <= arith && alu_cout;
            state_q    <= DONE;
          end
        end
        DONE: if (cmd_abort) begin
          rsp_result_q <= '0;
          rsp_cout_q   <= 1'b0;
          rsp_err_q    <= 1'b0;
          state_q      <= IDLE;
        end else if (rsp_ready) begin
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/alu_nibble_sequencer.md
Name: alu_nibble_sequencer

Overview:
- Multi-cycle controller that runs WIDTH-bit operations on the shared 4-bit decoder+ALU datapath, one nibble per cycle, LSB first.
- Propagates carry from one nibble to the next, assembles the result, and returns it over a valid/ready response channel.
- Sits between the command source (switch/UART front end) and the decoder/ALU.
- Also supplies the opcode and operand nibbles that the seven-segment display shows.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 4.
- NIBBLES, WIDTH/4, derived localparam; number of ALU passes per command.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  sequencer can accept a command.
- cmd_op  in  4  opcode; goes to the decoder's mode_d.
- cmd_a  in  WIDTH  operand A.
- cmd_b  in  WIDTH  operand B.
- cmd_cin  in  1  initial carry-in for arithmetic class.
- cmd_abort  in  1  abandon the in-flight command.
- alu_op  out  4  opcode to the decoder.
- alu_a  out  4  current A nibble.
- alu_b  out  4  current B nibble.
- alu_cin  out  1  current carry-in.
- alu_result  in  4  combinational ALU result for the current nibble.
- alu_cout  in  1  combinational ALU carry-out.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer takes result.
- rsp_result  out  WIDTH  assembled result.
- rsp_cout  out  1  final carry (arithmetic class), else 0.
- rsp_err  out  1  opcode rejected; result is 0.
- busy  out  1  high in RUN or DONE.

Behaviour:
- Reset: clears all state and outputs, asynchronously. State goes to IDLE. cmd_ready=1. rsp_valid=0, rsp_result=0, rsp_cout=0, rsp_err=0, busy=0. alu_op/alu_a/alu_b/alu_cin=0.
- Opcode classes:
  - 0x0-0x3 ARITH: carry chained; nibble 0 uses cmd_cin.
  - 0x4-0x7 LOGIC: alu_cin forced 0 every nibble; alu_cout ignored; rsp_cout=0.
  - 0x8-0xF REJECT: no ALU passes.
- IDLE state:
  - cmd_ready=1.
  - On cmd_valid at an edge, latch op, a, b, cin and clear the nibble index.
  - ARITH/LOGIC: go to RUN.
  - REJECT: go to DONE with rsp_err=1 and rsp_result=0.
- RUN state:
  - cmd_ready=0.
  - alu_op = latched op; alu_a/alu_b = nibble[idx] of the latched operands; alu_cin = carry register.
  - Each edge: write alu_result into rsp_result[4*idx +: 4], carry register <= alu_cout (ARITH), then idx++.
  - After the nibble NIBBLES-1 edge, go to DONE. rsp_cout = last alu_cout (ARITH) or 0.
- DONE state:
  - rsp_valid=1; result fields are stable.
  - On rsp_ready, go to IDLE at that edge.
  - A new command is accepted no earlier than the following cycle, so there is no bypass.
- Latency:
  - Accept edge E0; nibble captures on E1..E_NIBBLES.
  - rsp_valid is high from E_NIBBLES onward, i.e. NIBBLES cycles after acceptance (4 for WIDTH=16).
  - REJECT: rsp_valid is high 1 cycle after acceptance.
- ALU outputs are 0 whenever the state is not RUN.
- Abort:
  - cmd_abort in RUN: go to IDLE at the next edge. No response; partial result is discarded; rsp_result cleared.
  - cmd_abort in DONE: response is dropped; go to IDLE.
  - cmd_abort in IDLE: ignored, and a concurrent cmd_valid is still accepted.
- Back-pressure: rsp_ready held low keeps DONE indefinitely; cmd_valid is ignored meanwhile.
- rsp_ready while not in DONE: ignored.
- Width rule: the carry register is 1 bit; there is no overflow beyond WIDTH except rsp_cout.
- Reset mid-RUN: immediate return to the reset state; no response.

Optional Feature:
- Macro SEQ_FLAGS_EN.
- When defined, adds output rsp_zero (1 bit):
  - rsp_zero = 1 when rsp_result==0 while rsp_valid.
  - 0 on reset and outside DONE.
  - Computed from the registered result; no added latency.
- When undefined, the port and its logic are absent; the rest of the behaviour is identical.

Decomposition:
- Package alu_seq_pkg holds:
  - state enum {IDLE, RUN, DONE};
  - opcode class constants and a function op_class(op) returning ARITH/LOGIC/REJECT;
  - the nibble width constant 4.
- One natural sub-module: alu_seq_nibble_mux, which selects nibble[idx] from the latched operands. Everything else stays in the top.

Test Plan:
- The bench uses a behavioural ALU model: 0x0=ADD with carry, 0x4=AND. WIDTH=16.
- op=0x0, a=0x1234, b=0x0FCD, cin=0 -> rsp_result=0x2201, rsp_cout=0, rsp_valid exactly 4 cycles after accept.
- op=0x0, a=0xFFFF, b=0x0001, cin=0 -> rsp_result=0x0000, rsp_cout=1; alu_cin=1 on nibbles 1-3. With SEQ_FLAGS_EN, rsp_zero=1.
- op=0x4, a=0xF0F0, b=0xFF00, cin=1 -> rsp_result=0xF000, rsp_cout=0; alu_cin=0 on all 4 nibbles.
- op=0xA -> rsp_err=1, rsp_result=0, rsp_valid 1 cycle after accept, no cycle with non-zero alu_op.
- Abort and reset cases:
  - Start op 0x0, assert cmd_abort on the 2nd RUN cycle -> IDLE next edge, no rsp_valid.
  - Separately, drop rst_n mid-RUN -> all outputs at reset values without a clock edge.
- Hold rsp_ready=0 for 10 cycles with cmd_valid high -> rsp fields stable, cmd_ready=0. Then raise rsp_ready -> IDLE, second command accepted the cycle after.
